// File: rtl/chan8_pkg.sv
// rtl/chan8_pkg.sv - shared defaults, FSM state type and counter sizing for the channel scheduler
package chan8_pkg;

  localparam int NUM_CH    = 8;
  localparam int DATA_W    = 8;
  localparam int BURST_DEF = 4;
  localparam int ID_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // A one-beat burst still needs a 1-bit counter to keep the vectors legal.
  function automatic int cnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  localparam int CNT_W = cnt_width(BURST_DEF);

endpackage

// File: rtl/chan8_rr_pick.sv
// rtl/chan8_rr_pick.sv - first asserted request at or above base, wrapping; base=0 gives fixed priority
module chan8_rr_pick
  import chan8_pkg::*;
#(
  parameter int N = NUM_CH
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] base,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] idx,
  output logic            found
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so that bit 0 of rot is channel 'base'; the lowest set bit of rot wins.
  always_comb begin
    dbl   = {req, req} >> base;
    rot   = dbl[N-1:0];
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = ID_W'((int'(base) + k) % N);
      end
    end
  end

  assign winner = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/chan8_sched.sv
// rtl/chan8_sched.sv - N-channel burst scheduler with fixed or round-robin arbitration
module chan8_sched
  import chan8_pkg::*;
#(
  parameter int N         = NUM_CH,
  parameter int W         = DATA_W,
  parameter int MAX_BURST = BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              hold,
  input  logic [N-1:0]      req,
  input  logic [N*W-1:0]    data,
  input  logic              out_ready,
  output logic [N-1:0]      gnt,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [ID_W-1:0]   out_id,
  output logic              busy
);

  localparam int            CW       = cnt_width(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [ID_W-1:0] base;
  logic [N-1:0]    pick_onehot;
  logic [ID_W-1:0] pick_idx;
  logic            pick_found;
  logic            cur_req;

  assign base    = mode ? ptr_q : '0;
  assign cur_req = req[id_q];

  chan8_rr_pick #(.N(N)) u_pick (
    .req    (req),
    .base   (base),
    .winner (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // A dropped request ends the burst before out_ready is even considered.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (!hold && pick_found) begin
          state_d = SEND;
          gnt_d   = pick_onehot;
          id_d    = pick_idx;
          cnt_d   = '0;
          ptr_d   = (pick_idx == ID_W'(N - 1)) ? '0 : pick_idx + ID_W'(1);
        end
      end
      SEND: begin
        if (!cur_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (out_ready) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    out_id    = id_q;
    busy      = (state_q == SEND);
    out_valid = (state_q == SEND) && cur_req;
    out_data  = out_valid ? data[int'(id_q)*W +: W] : '0;
  end

endmodule

// File: tb/tb_chan8_sched.sv
// tb/tb_chan8_sched.sv - directed scenarios plus random soak against a behavioural scheduler model
module tb_chan8_sched;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst, mode, hold, out_ready;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_id;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  logic m_send;
  int   m_id, m_beats, m_ptr;

  int         dut_beats;
  logic       prev_busy;
  logic [7:0] prev_gnt;
  int         grant_ids[$];

  logic [7:0] g37[8];
  logic [2:0] id37[8];

  chan8_sched #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .hold      (hold),
    .req       (req),
    .data      (data),
    .out_ready (out_ready),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Winner chosen from the list of requesting channels in ascending order.
  function automatic int model_pick(input logic [7:0] r, input logic rr, input int p);
    int cand[$];
    for (int i = 0; i < N; i++) if (r[i]) cand.push_back(i);
    if (cand.size() == 0) return -1;
    if (rr) foreach (cand[k]) if (cand[k] >= p) return cand[k];
    return cand[0];
  endfunction

  task automatic run_cycle(input logic r, input logic m, input logic h,
                           input logic [7:0] rq, input logic rdy);
    logic ev;
    int   w;
    @(negedge clk);
    rst       = r;
    mode      = m;
    hold      = h;
    req       = rq;
    out_ready = rdy;
    data      = {$urandom(), $urandom()};
    #1;
    ev = m_send && rq[m_id];
    check_eq("gnt", gnt, m_send ? (64'(1) << m_id) : 64'(0));
    check_eq("busy", busy, m_send);
    check_eq("out_valid", out_valid, ev);
    check_eq("out_data", out_data, ev ? 64'(data[m_id*W +: W]) : 64'(0));
    if (m_send) check_eq("out_id", out_id, m_id);
    check_eq("gnt_onehot0", $onehot0(gnt), 1);
    if (!out_valid) check_eq("data_zero_no_valid", out_data, 0);
    if (prev_busy && !busy) begin
      check_eq("burst_le_max", dut_beats <= MB, 1);
      dut_beats = 0;
    end
    if (r) dut_beats = 0;
    else if (out_valid && rdy) dut_beats++;
    if (gnt != 0 && prev_gnt == 0) grant_ids.push_back(int'(out_id));
    prev_busy = busy;
    prev_gnt  = gnt;

    if (r) begin
      m_send = 1'b0; m_id = 0; m_beats = 0; m_ptr = 0;
    end else if (!m_send) begin
      if (!h) begin
        w = model_pick(rq, m, m_ptr);
        if (w >= 0) begin
          m_send = 1'b1; m_id = w; m_beats = 0; m_ptr = (w + 1) % N;
        end
      end
    end else if (!rq[m_id]) begin
      m_send = 1'b0;
    end else if (rdy) begin
      m_beats++;
      if (m_beats == MB) m_send = 1'b0;
    end
  endtask

  initial begin
    logic       smode;
    logic [7:0] rq;
    rst = 1'b1; mode = 1'b0; hold = 1'b0; req = '0; data = '0; out_ready = 1'b0;
    m_send = 1'b0; m_id = 0; m_beats = 0; m_ptr = 0;
    dut_beats = 0; prev_busy = 1'b0; prev_gnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_id", out_id, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);

    // Fixed priority, two requesters
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 8'h24, 1'b1);
      g37[c]  = gnt;
      id37[c] = out_id;
    end
    check_eq("fx_c0_gnt", g37[0], 8'h00);
    check_eq("fx_c1_gnt", g37[1], 8'h04);
    check_eq("fx_c1_id", id37[1], 2);
    check_eq("fx_c4_gnt", g37[4], 8'h04);
    check_eq("fx_bubble_gnt", g37[5], 8'h00);
    check_eq("fx_regrant_gnt", g37[6], 8'h04);

    // Round-robin sweep over all channels
    run_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    grant_ids.delete();
    repeat (46) run_cycle(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
    check_eq("rr_grant_count", grant_ids.size() >= 9, 1);
    for (int k = 0; k < 9 && k < grant_ids.size(); k++)
      check_eq($sformatf("rr_order_%0d", k), grant_ids[k], k % N);

    // Stall then request drop on channel 5
    run_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    run_cycle(1'b0, 1'b0, 1'b0, 8'h20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b0, 1'b0, 1'b0, 8'h20, 1'b0);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_gnt", gnt, 8'h20);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("drop_valid", out_valid, 0);
    run_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check_eq("drop_gnt", gnt, 0);
    check_eq("drop_busy", busy, 0);

    // Hold inhibits grants
    repeat (3) begin
      run_cycle(1'b0, 1'b0, 1'b1, 8'h81, 1'b1);
      check_eq("hold_gnt", gnt, 0);
    end
    run_cycle(1'b0, 1'b0, 1'b0, 8'h81, 1'b1);
    check_eq("hold_release_gnt0", gnt, 0);
    run_cycle(1'b0, 1'b0, 1'b0, 8'h81, 1'b1);
    check_eq("hold_release_gnt1", gnt, 8'h01);

    // Reset in the middle of a channel 3 burst
    run_cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 8'h08, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 8'h08, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 8'h08, 1'b1);
    run_cycle(1'b1, 1'b1, 1'b0, 8'h08, 1'b1);
    run_cycle(1'b0, 1'b1, 1'b0, 8'h88, 1'b1);
    check_eq("mrst_gnt", gnt, 0);
    check_eq("mrst_out_id", out_id, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_out_valid", out_valid, 0);
    check_eq("mrst_out_data", out_data, 0);
    run_cycle(1'b0, 1'b1, 1'b0, 8'h88, 1'b1);
    check_eq("mrst_regrant_gnt", gnt, 8'h08);
    check_eq("mrst_regrant_id", out_id, 3);

    // Random soak
    smode = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 49) == 0) smode = ~smode;
      rq = 8'($urandom()) | 8'($urandom());
      if ($urandom_range(0, 9) == 0) rq = '0;
      run_cycle($urandom_range(0, 499) == 0, smode, $urandom_range(0, 4) == 0,
                rq, $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chan8_sched.md
CHAN8_SCHED -- requirements
Module: chan8_sched

Interface
REQ-001 Parameter N, default 8, number of requester channels.
REQ-002 Parameter W, default 8, data width per channel.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant (power of two, 1..16).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 hold  input  1  1 = inhibit new grants; any current burst continues.
REQ-008 req  input  N  per-channel request, level-sensitive.
REQ-009 data  input  N*W  channel i data in bits [i*W+W-1 : i*W].
REQ-010 out_ready  input  1  downstream accepts a beat.
REQ-011 gnt  output  N  one-hot grant, registered.
REQ-012 out_valid  output  1  beat available.
REQ-013 out_data  output  W  data of granted channel.
REQ-014 out_id  output  3  index of granted channel.
REQ-015 busy  output  1  high in SEND state.

Function
REQ-016 FSM SHALL have two states: IDLE and SEND.
REQ-017 In IDLE with hold=0 and req!=0, the block SHALL select a winner, register gnt/out_id, clear the beat counter and enter SEND on the next edge: grant latency is one cycle.
REQ-018 In IDLE with hold=1 or req=0, the block SHALL stay in IDLE with gnt=0.
REQ-019 Fixed mode SHALL select the lowest asserted req index.
REQ-020 Round-robin mode SHALL select the first asserted req at or above ptr, wrapping from N-1 to 0.
REQ-021 On every grant (either mode), ptr SHALL become (winner+1) mod N.
REQ-022 mode and hold SHALL be sampled only in IDLE; changes during SEND have no effect on the current burst.
REQ-023 In SEND, out_valid SHALL equal req[out_id] (combinational).
REQ-024 In SEND, out_data SHALL equal the out_id slice of data; out_data SHALL be 0 whenever out_valid=0.
REQ-025 A beat transfers when out_valid=1 and out_ready=1; the beat counter SHALL then increment.
REQ-026 SEND SHALL return to IDLE when a beat transfers with counter = MAX_BURST-1.
REQ-027 SEND SHALL return to IDLE when req[out_id]=0; a drop takes priority, and no beat transfers that cycle.
REQ-028 On the return to IDLE, gnt SHALL clear on the same edge, leaving one mandatory IDLE bubble cycle before the next grant.
REQ-029 out_valid=1 with out_ready=0 SHALL hold the state, the counter and out_data; there is no timeout.
REQ-030 gnt SHALL never have more than one bit set; gnt=0 SHALL hold in IDLE.

Reset
REQ-031 rst=1 at a clock edge SHALL force: state IDLE, gnt=0, out_id=0, ptr=0, counter=0, busy=0, out_valid=0, out_data=0.
REQ-032 Reset asserted during SEND SHALL abort the burst with no beat counted that cycle.
REQ-033 In the first cycle after reset release, the block SHALL arbitrate normally.

Structure
REQ-034 Package chan8_pkg SHALL hold N, W and MAX_BURST defaults, the state enum {IDLE, SEND} and the counter width constant $clog2(MAX_BURST).
REQ-035 The rotating priority pick SHALL be a sub-module chan8_rr_pick with inputs req and base and outputs a one-hot winner, an index and found; fixed mode uses base=0.
REQ-036 All outputs except out_valid and out_data SHALL be driven from registers.

Verification
REQ-037 Fixed mode, req=8'b0010_0100, out_ready=1 -> gnt=8'b0000_0100, out_id=2 one cycle later, 4 beats of data[23:16], IDLE bubble, then gnt=8'b0000_0100 again.
REQ-038 RR mode, req=8'hFF held, out_ready=1 -> grants visit ids 0,1,...,7,0 in order, each for 4 beats separated by one bubble cycle.
REQ-039 Channel 5 granted, out_ready=0 for 3 cycles, then req[5] drops -> out_valid=1 and counter=0 for those 3 cycles, then IDLE with gnt=0 the next cycle.
REQ-040 hold=1 with req=8'h81 -> gnt stays 0; hold falls -> gnt=8'h01 one cycle later (fixed mode).
REQ-041 rst pulsed at beat 2 of a channel 3 burst -> all outputs 0 and ptr=0 next cycle; RR with req=8'h08 then grants id 3.
REQ-042 A random req/out_ready soak of 10k cycles SHALL confirm that gnt is always one-hot or zero, that no burst exceeds MAX_BURST beats, and that out_data equals 0 whenever out_valid=0.
